// File: rtl/confreg_arbiter.sv
// ============================================================================
// Module  : confreg_arbiter
// Brief   : Round-robin two-master arbiter with bounded lock for the config-register port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module confreg_arbiter #(
  parameter int RESP_LAT = 1,
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [3:0]  m0_wen,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [3:0]  m1_wen,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        conf_en,
  output logic [3:0]  conf_wen,
  output logic [31:0] conf_addr,
  output logic [31:0] conf_wdata,
  input  logic [31:0] conf_rdata,
  output logic        lock_timeout
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic [7:0] c_LOCK_LAST = 8'(LOCK_MAX - 1);

  state_t      r_state, w_state_next;
  logic        r_prio, w_prio_next;
  logic [7:0]  r_lock_cnt, w_lock_cnt_next;
  logic        r_lock_timeout, w_timeout_set;
  logic        w_gnt0, w_gnt1;
  logic        w_g0, w_g1;
  logic        w_en;
  logic [3:0]  w_wen;
  logic [31:0] w_addr, w_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ARB;
      r_prio         <= 1'b0;
      r_lock_cnt     <= 8'd0;
      r_lock_timeout <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_prio     <= w_prio_next;
      r_lock_cnt <= w_lock_cnt_next;
      if (w_timeout_set) r_lock_timeout <= 1'b1;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_prio_next     = r_prio;
    w_lock_cnt_next = r_lock_cnt;
    w_timeout_set   = 1'b0;
    w_gnt0          = 1'b0;
    w_gnt1          = 1'b0;
    case (r_state)
      ARB: begin
        if (m0_req && (!m1_req || !r_prio)) w_gnt0 = 1'b1;
        else if (m1_req)                    w_gnt1 = 1'b1;
        if (w_gnt0) begin
          w_prio_next = 1'b1;
          if (m0_lock) begin
            w_state_next    = LOCK0;
            w_lock_cnt_next = 8'd0;
          end
        end else if (w_gnt1) begin
          w_prio_next = 1'b0;
          if (m1_lock) begin
            w_state_next    = LOCK1;
            w_lock_cnt_next = 8'd0;
          end
        end
      end
      LOCK0: begin
        w_gnt0          = m0_req;
        w_lock_cnt_next = r_lock_cnt + 8'd1;
        // Timeout exit fires regardless of whether the owner is requesting
        if (!m0_lock) begin
          w_state_next = ARB;
          w_prio_next  = 1'b1;
        end else if (r_lock_cnt == c_LOCK_LAST) begin
          w_state_next  = ARB;
          w_prio_next   = 1'b1;
          w_timeout_set = 1'b1;
        end
      end
      LOCK1: begin
        w_gnt1          = m1_req;
        w_lock_cnt_next = r_lock_cnt + 8'd1;
        if (!m1_lock) begin
          w_state_next = ARB;
          w_prio_next  = 1'b0;
        end else if (r_lock_cnt == c_LOCK_LAST) begin
          w_state_next  = ARB;
          w_prio_next   = 1'b0;
          w_timeout_set = 1'b1;
        end
      end
      default: w_state_next = ARB;
    endcase
  end

  // Grants are masked during reset so every output reads zero while rst is high
  assign w_g0    = w_gnt0 & ~rst;
  assign w_g1    = w_gnt1 & ~rst;
  assign w_en    = w_g0 | w_g1;
  assign w_wen   = w_g0 ? m0_wen   : (w_g1 ? m1_wen   : 4'd0);
  assign w_addr  = w_g0 ? m0_addr  : (w_g1 ? m1_addr  : 32'd0);
  assign w_wdata = w_g0 ? m0_wdata : (w_g1 ? m1_wdata : 32'd0);

  assign m0_gnt       = w_g0;
  assign m1_gnt       = w_g1;
  assign conf_en      = w_en;
  assign conf_wen     = w_wen;
  assign conf_addr    = w_addr;
  assign conf_wdata   = w_wdata;
  assign lock_timeout = r_lock_timeout;

  logic [RESP_LAT-1:0] r_pv, r_pid, r_pwr;

  generate
    if (RESP_LAT == 1) begin : g_pipe_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pv  <= '0;
          r_pid <= '0;
          r_pwr <= '0;
        end else begin
          r_pv  <= w_en;
          r_pid <= w_g1;
          r_pwr <= |w_wen;
        end
      end
    end else begin : g_pipe_multi
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pv  <= '0;
          r_pid <= '0;
          r_pwr <= '0;
        end else begin
          r_pv  <= {r_pv[RESP_LAT-2:0], w_en};
          r_pid <= {r_pid[RESP_LAT-2:0], w_g1};
          r_pwr <= {r_pwr[RESP_LAT-2:0], |w_wen};
        end
      end
    end
  endgenerate

  logic w_out_v, w_out_id, w_out_wr;
  assign w_out_v  = r_pv[RESP_LAT-1];
  assign w_out_id = r_pid[RESP_LAT-1];
  assign w_out_wr = r_pwr[RESP_LAT-1];

  assign m0_rvalid = w_out_v & ~w_out_id;
  assign m1_rvalid = w_out_v &  w_out_id;
  assign m0_rdata  = (m0_rvalid && !w_out_wr) ? conf_rdata : 32'd0;
  assign m1_rdata  = (m1_rvalid && !w_out_wr) ? conf_rdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_confreg_arbiter.sv
// ============================================================================
// Module  : tb_confreg_arbiter
// Brief   : Vector-table bench with response scoreboard for confreg_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_confreg_arbiter;

  localparam int RESP_LAT = 1;
  localparam int LOCK_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_lock = 1'b0, m1_req = 1'b0, m1_lock = 1'b0;
  logic [3:0]  m0_wen = '0, m1_wen = '0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        conf_en;
  logic [3:0]  conf_wen;
  logic [31:0] conf_addr, conf_wdata;
  logic [31:0] conf_rdata = '0;
  logic        lock_timeout;

  confreg_arbiter #(.RESP_LAT(RESP_LAT), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .conf_en(conf_en), .conf_wen(conf_wen), .conf_addr(conf_addr), .conf_wdata(conf_wdata),
    .conf_rdata(conf_rdata), .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  // Register block: registered read of the pre-write contents, byte-enabled write
  logic [31:0] regs [4] = '{32'h0, 32'hCAFE0001, 32'h12345678, 32'h0};
  always @(posedge clk) begin
    if (conf_en) begin
      conf_rdata <= regs[conf_addr[3:2]];
      for (int b = 0; b < 4; b++)
        if (conf_wen[b]) regs[conf_addr[3:2]][8*b +: 8] <= conf_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic        rs;
    logic        r0, l0;
    logic [3:0]  w0;
    logic [31:0] a0, d0;
    logic        r1, l1;
    logic [3:0]  w1;
    logic [31:0] a1, d1;
    logic        g0, g1, to;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        id;
    logic [31:0] data;
  } exp_t;

  vec_t        rows[$];
  exp_t        sb[$];
  logic [31:0] shadow [4] = '{32'h0, 32'hCAFE0001, 32'h12345678, 32'h0};
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  function automatic vec_t mk(int rs, int r0, int l0, int w0, int a0, int d0,
                              int r1, int l1, int w1, int a1, int d1,
                              int g0, int g1, int to);
    vec_t v;
    v.rs = rs[0]; v.r0 = r0[0]; v.l0 = l0[0]; v.w0 = w0[3:0]; v.a0 = a0; v.d0 = d0;
    v.r1 = r1[0]; v.l1 = l1[0]; v.w1 = w1[3:0]; v.a1 = a1; v.d1 = d1;
    v.g0 = g0[0]; v.g1 = g1[0]; v.to = to[0];
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    exp_t        e;
    logic        ev0, ev1;
    logic [31:0] ed0, ed1, ea, ed;
    logic [3:0]  ew;
    @(posedge clk);
    #1;
    rst = v.rs;
    m0_req = v.r0; m0_lock = v.l0; m0_wen = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_lock = v.l1; m1_wen = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
    @(negedge clk);
    if (v.rs) sb.delete();
    ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      if (e.id) begin ev1 = 1'b1; ed1 = e.data; end
      else      begin ev0 = 1'b1; ed0 = e.data; end
    end
    chk("m0_rvalid", 32'(m0_rvalid), 32'(ev0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(ev1));
    chk("m0_rdata", m0_rdata, ed0);
    chk("m1_rdata", m1_rdata, ed1);
    chk("m0_gnt", 32'(m0_gnt), 32'(v.g0));
    chk("m1_gnt", 32'(m1_gnt), 32'(v.g1));
    chk("lock_timeout", 32'(lock_timeout), 32'(v.to));
    ew = v.g0 ? v.w0 : (v.g1 ? v.w1 : 4'd0);
    ea = v.g0 ? v.a0 : (v.g1 ? v.a1 : 32'd0);
    ed = v.g0 ? v.d0 : (v.g1 ? v.d1 : 32'd0);
    chk("conf_en", 32'(conf_en), 32'(v.g0 | v.g1));
    chk("conf_wen", 32'(conf_wen), 32'(ew));
    chk("conf_addr", conf_addr, ea);
    chk("conf_wdata", conf_wdata, ed);
    if (v.g0 | v.g1) begin
      e.cyc  = cyc + RESP_LAT;
      e.id   = v.g1;
      e.data = (ew != 4'd0) ? 32'd0 : shadow[ea[3:2]];
      sb.push_back(e);
      for (int b = 0; b < 4; b++)
        if (ew[b]) shadow[ea[3:2]][8*b +: 8] = ed[8*b +: 8];
    end
    cyc++;
  endtask

  initial begin
    // Reset with both masters requesting: everything must read zero
    rows.push_back(mk(1, 1,0,0,8,0,       1,0,0,4,0,       0,0,0));
    rows.push_back(mk(1, 1,0,0,8,0,       1,0,0,4,0,       0,0,0));
    // Contention alternates starting with m0
    rows.push_back(mk(0, 1,0,0,8,0,       1,0,0,4,0,       1,0,0));
    rows.push_back(mk(0, 1,0,0,8,0,       1,0,0,4,0,       0,1,0));
    rows.push_back(mk(0, 1,0,0,8,0,       1,0,0,4,0,       1,0,0));
    rows.push_back(mk(0, 1,0,0,8,0,       1,0,0,4,0,       0,1,0));
    rows.push_back(mk(0, 0,0,0,0,0,       0,0,0,0,0,       0,0,0));
    // Single read of 0x8
    rows.push_back(mk(0, 1,0,0,8,0,       0,0,0,0,0,       1,0,0));
    rows.push_back(mk(0, 0,0,0,0,0,       0,0,0,0,0,       0,0,0));
    // Write ack then read-back of 0x0
    rows.push_back(mk(0, 0,0,0,0,0,       1,0,15,0,'hA5,   0,1,0));
    rows.push_back(mk(0, 0,0,0,0,0,       1,0,0,0,0,       0,1,0));
    rows.push_back(mk(0, 0,0,0,0,0,       0,0,0,0,0,       0,0,0));
    // Lock RMW by m0 while m1 requests continuously
    rows.push_back(mk(0, 1,1,0,8,0,       1,0,0,4,0,       1,0,0));
    rows.push_back(mk(0, 1,1,15,8,'h1234567F, 1,0,0,4,0,   1,0,0));
    rows.push_back(mk(0, 0,1,0,0,0,       1,0,0,4,0,       0,0,0));
    rows.push_back(mk(0, 0,0,0,0,0,       1,0,0,4,0,       0,0,0));
    rows.push_back(mk(0, 0,0,0,0,0,       1,0,0,4,0,       0,1,0));
    rows.push_back(mk(0, 0,0,0,0,0,       1,0,0,8,0,       0,1,0));
    rows.push_back(mk(0, 0,0,0,0,0,       0,0,0,0,0,       0,0,0));
    // Lock held indefinitely: forced release after LOCK_MAX cycles
    rows.push_back(mk(0, 1,1,0,8,0,       1,0,0,4,0,       1,0,0));
    for (int k = 0; k < LOCK_MAX; k++)
      rows.push_back(mk(0, 1,1,0,0,0,     1,0,0,4,0,       1,0,0));
    rows.push_back(mk(0, 1,1,0,0,0,       1,0,0,4,0,       0,1,1));
    rows.push_back(mk(0, 1,0,0,0,0,       0,0,0,0,0,       1,0,1));
    rows.push_back(mk(0, 0,0,0,0,0,       0,0,0,0,0,       0,0,1));
    // Reset the cycle after a grant: no response, flag cleared, m0 first after
    rows.push_back(mk(0, 0,0,0,0,0,       1,0,0,4,0,       0,1,1));
    rows.push_back(mk(1, 1,0,0,8,0,       1,0,0,4,0,       0,0,0));
    rows.push_back(mk(0, 1,0,0,8,0,       1,0,0,4,0,       1,0,0));
    rows.push_back(mk(0, 0,0,0,0,0,       0,0,0,0,0,       0,0,0));

    for (int i = 0; i < rows.size(); i++) apply(rows[i]);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/confreg_arbiter.md
# confreg_arbiter

Two-master arbiter that shares the single SRAM-like configuration-register port (LED, seven-segment, switch and virtual-UART registers) between two requesters, such as the CPU data port and a debug/loader master. It grants one access per cycle by round-robin and supports a bounded lock for atomic read-modify-write sequences. It returns each response to the issuing master after the fixed read latency of the register block.

## Interface
- RESP_LAT, 1: cycles from a granted access to its response; the register block registers `conf_rdata`, so RESP_LAT = 1. Legal range is 1..4.
- LOCK_MAX, 16: maximum number of consecutive cycles one master may hold the lock. Legal range is 2..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock domain, asynchronous, active-high.
- m0_req / m1_req  in  1  access request; held with its command until granted.
- m0_lock / m1_lock  in  1  requests exclusive ownership after the current grant.
- m0_wen / m1_wen  in  4  byte write enables; 0 means read.
- m0_addr / m1_addr  in  32  register address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_gnt / m1_gnt  out  1  combinational; the command is accepted this cycle.
- m0_rvalid / m1_rvalid  out  1  response pulse, exactly one per grant.
- m0_rdata / m1_rdata  out  32  read data, valid with rvalid; 0 for writes and whenever rvalid = 0.
- conf_en  out  1  access strobe to the register block.
- conf_wen  out  4  write enables forwarded from the granted master.
- conf_addr  out  32  address forwarded from the granted master.
- conf_wdata  out  32  write data forwarded from the granted master.
- conf_rdata  in  32  registered read data from the register block.
- lock_timeout  out  1  sticky flag; set on a forced lock release, cleared only by rst.

## Operation
- FSM states are ARB, LOCK0 and LOCK1. The reset state is ARB.
- Registered state:
  - `prio` (reset 0) selects the preferred master in ARB.
  - `lock_cnt` (8 bits, reset 0) counts cycles spent in a LOCK state.
- ARB grant rules:
  - If only one master requests, that master is granted.
  - If both request, master `prio` is granted.
  - After a grant to master n, `prio` becomes 1-n.
  - If the granted master also has lock = 1, the next state is LOCKn and `lock_cnt` is cleared to 0.
- LOCKn grant rules:
  - Only master n can be granted (gnt = req_n). The other master's gnt is 0.
  - `lock_cnt` increments every cycle.
- Leaving LOCKn (both exits go to ARB with `prio` = 1-n):
  - If lock_n = 0 when sampled at an edge, the FSM moves to ARB.
  - If lock_n = 1 and `lock_cnt` = LOCK_MAX-1, the FSM moves to ARB and sets lock_timeout.
  - The timeout exit happens whether or not master n is requesting.
- Port multiplexing:
  - conf_en = m0_gnt | m1_gnt.
  - conf_wen, conf_addr and conf_wdata come from the granted master.
  - When there is no grant, conf_wen, conf_addr and conf_wdata are all 0.
- Response pipeline:
  - The pipeline is RESP_LAT stages deep; each stage holds {valid, id, is_write}.
  - A stage is loaded on every grant, with is_write = (wen != 0).
  - At the pipeline output, mid_rvalid = 1.
  - At the pipeline output, mid_rdata = is_write ? 0 : conf_rdata.
- Back-to-back grants are allowed on every cycle. A master may receive consecutive grants.
- Reset mid-operation:
  - All pipeline stages are invalidated immediately.
  - No rvalid is produced for accesses in flight when reset asserts.
  - The FSM returns to ARB.

## Timing
- Reset values:
  - conf_en = 0, conf_wen = 0, conf_addr = 0, conf_wdata = 0.
  - m*_gnt = 0, m*_rvalid = 0, m*_rdata = 0.
  - lock_timeout = 0.
- Grant timing:
  - gnt is combinational, in the same cycle as req.
  - The command is taken by the register block at the edge that ends the grant cycle T.
- Response timing:
  - For a grant in cycle T, rvalid is high in cycle T+RESP_LAT for exactly one cycle.
  - With RESP_LAT = 1, rdata equals the value the register block latched at the end of cycle T.
- Lock timing:
  - A lock grant in cycle T puts the FSM in LOCKn from cycle T+1.
  - The longest lock tenure is cycles T+1 through T+LOCK_MAX.
- Simultaneous events:
  - Both masters requesting in ARB: one grant only, chosen by `prio`.
  - A master deasserting lock and requesting in the same cycle: that request is still a LOCK-state grant. The lock release takes effect at the edge.
- Write semantics: a write and a read to the same register are ordered by grant order.

## Test plan
- **Single read.** m0 reads addr 0x0008 with num register = 0x12345678.
  - m0_gnt = 1 in cycle T.
  - m0_rvalid = 1 in T+1 with m0_rdata = 0x12345678.
  - m1_rvalid stays 0.
- **Contention after reset.** Both masters request continuously.
  - Grants alternate m0, m1, m0, m1.
  - Each master receives exactly one rvalid per grant, tagged correctly.
- **Write ack.** m1 writes 0xA5 to 0x0000 with wen = 0xF.
  - conf_en = 1, conf_wen = 0xF, conf_wdata = 0xA5.
  - m1_rvalid = 1 next cycle with m1_rdata = 0.
  - A following read of 0x0000 returns 0xA5.
- **Lock RMW.** m0 locks for 3 cycles while m1 requests continuously.
  - m1_gnt = 0 throughout LOCK0.
  - m1 is granted in the first ARB cycle.
  - lock_timeout stays 0.
- **Lock timeout.** m0 holds lock indefinitely with LOCK_MAX = 4.
  - The FSM leaves LOCK0 after 4 cycles.
  - lock_timeout = 1 and m1 is granted next.
  - lock_timeout stays 1 until rst.
- **Reset mid-flight.** Assert rst in the cycle after a grant.
  - No rvalid appears.
  - All outputs are 0 during reset.
  - The first grant after reset goes to m0.
